// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus grant arbiter.
package bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/bus_prio_pick.sv
// Combinational highest-set-bit picker: returns index of the top set bit.
module bus_prio_pick #(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Ascending scan so the last (highest) set bit overwrites earlier hits.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Registered N-way bus arbiter: fixed-priority or round-robin, with max-hold timeout.
module bus_grant_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N        = 32,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic             gnt_valid,
    output logic             timeout_pulse
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HC_MAX = '1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [HC_W-1:0]   r_hold;
    logic [IDX_W-1:0]  r_idx;
    logic [N-1:0]      r_onehot;
    logic              r_valid;
    logic              r_pulse;

    logic [IDX_W-1:0]  w_shift;
    logic [N-1:0]      w_rot;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic              w_req_cur;
    logic              w_timeout;
    logic              w_grant;
    logic              w_release;
    logic              w_to;

    // Rotating by rr_ptr puts req[rr_ptr-1] at the top bit, so the
    // highest-bit picker searches downward from rr_ptr-1 modulo N.
    assign w_shift = (mode == MODE_RR) ? r_rr_ptr : '0;
    assign w_rot   = N'({req, req} >> w_shift);

    bus_prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_vec   (w_rot),
        .o_idx   (w_pick_idx),
        .o_found (w_found)
    );

    always_comb begin
        int v;
        v = int'(w_pick_idx) + int'(w_shift);
        if (v >= N) begin
            v = v - N;
        end
        w_win = IDX_W'(v);
    end

    assign w_req_cur = req[r_idx];
    assign w_timeout = (MAX_HOLD != 0) && (int'(r_hold) >= MAX_HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_to        = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (en && w_found) begin
                    w_state_nxt = ARB_GRANT;
                    w_grant     = 1'b1;
                end
            end
            ARB_GRANT: begin
                // A voluntary drop wins over a coincident timeout.
                if (!en || !w_req_cur) begin
                    w_state_nxt = ARB_IDLE;
                    w_release   = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = ARB_IDLE;
                    w_release   = 1'b1;
                    w_to        = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= '0;
            r_hold   <= '0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_to;
            if (w_grant) begin
                r_idx    <= w_win;
                r_onehot <= {{(N-1){1'b0}}, 1'b1} << w_win;
                r_valid  <= 1'b1;
                r_hold   <= HC_W'(1);
                if (mode == MODE_RR) begin
                    r_rr_ptr <= w_win;
                end
            end else if (w_release) begin
                r_idx    <= '0;
                r_onehot <= '0;
                r_valid  <= 1'b0;
                r_hold   <= '0;
            end else if (r_state == ARB_GRANT && r_hold != HC_MAX) begin
                r_hold <= r_hold + HC_W'(1);
            end
        end
    end

    assign gnt_idx       = r_idx;
    assign gnt_onehot    = r_onehot;
    assign gnt_valid     = r_valid;
    assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: directed scenarios plus random traffic.
module tb_bus_grant_arbiter;

    localparam int N     = 32;
    localparam int IDX_W = 5;
    localparam int MAXH  = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic             mode;
    logic [N-1:0]     req;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic             gnt_valid;
    logic             timeout_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_g;
    int m_idx;
    int m_hold;
    int m_ptr;
    bit m_pulse;

    always #5 clock = ~clock;

    bus_grant_arbiter #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAXH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .mode          (mode),
        .req           (req),
        .gnt_idx       (gnt_idx),
        .gnt_onehot    (gnt_onehot),
        .gnt_valid     (gnt_valid),
        .timeout_pulse (timeout_pulse)
    );

    function automatic int pick(logic [N-1:0] r, bit rr, int ptr);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (ptr - k + N) % N;
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        if (reset) begin
            m_g = 0; m_idx = 0; m_hold = 0; m_ptr = 0; m_pulse = 0;
        end else if (!m_g) begin
            m_pulse = 0;
            if (en && req != '0) begin
                w = pick(req, mode, m_ptr);
                m_g = 1; m_idx = w; m_hold = 1;
                if (mode) m_ptr = w;
            end
        end else begin
            m_pulse = 0;
            if (!en || !req[m_idx]) begin
                m_g = 0; m_idx = 0; m_hold = 0;
            end else if (m_hold >= MAXH) begin
                m_g = 0; m_idx = 0; m_hold = 0; m_pulse = 1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic step();
        logic [31:0] exp_oh;
        @(posedge clock);
        model_edge();
        #1;
        exp_oh = m_g ? (32'd1 << m_idx) : 32'd0;
        chk("valid", {31'd0, gnt_valid}, {31'd0, m_g});
        chk("idx", {27'd0, gnt_idx}, m_idx);
        chk("onehot", gnt_onehot, exp_oh);
        chk("pulse", {31'd0, timeout_pulse}, {31'd0, m_pulse});
    endtask

    initial begin
        int ord [4];
        ord = '{8, 4, 0, 8};
        reset = 1'b1; en = 1'b0; mode = 1'b0; req = '0;
        step();
        step();
        reset = 1'b0;
        en = 1'b1;

        // Fixed priority: highest index wins, then lower one after the gap
        req = 32'h8000_0002;
        step();
        chk("t1_idx", {27'd0, gnt_idx}, 31);
        chk("t1_oh", gnt_onehot, 32'h8000_0000);
        chk("t1_valid", {31'd0, gnt_valid}, 1);
        req = 32'h0000_0002;
        step();
        chk("t2_gap_valid", {31'd0, gnt_valid}, 0);
        chk("t2_gap_oh", gnt_onehot, 0);
        step();
        chk("t2_idx", {27'd0, gnt_idx}, 1);
        chk("t2_oh", gnt_onehot, 32'h0000_0002);
        req = '0;
        step();
        step();

        // Round robin order 8,4,0,8 with a one-cycle gap
        mode = 1'b1;
        req = 32'h0000_0111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_rr_idx", {27'd0, gnt_idx}, ord[k]);
            step();
            req[ord[k]] = 1'b0;
            step();
            chk("t3_gap", {31'd0, gnt_valid}, 0);
            req = 32'h0000_0111;
        end
        req = '0;
        step();

        // Timeout after MAXH valid cycles, then re-grant
        mode = 1'b0;
        req = 32'h1 << 5;
        step();
        for (int i = 0; i < MAXH; i++) begin
            chk("t4_hold", {31'd0, gnt_valid}, 1);
            step();
        end
        chk("t4_to_valid", {31'd0, gnt_valid}, 0);
        chk("t4_to_pulse", {31'd0, timeout_pulse}, 1);
        step();
        chk("t4_regrant", {27'd0, gnt_idx}, 5);
        chk("t4_pulse_off", {31'd0, timeout_pulse}, 0);
        req = '0;
        step();
        step();

        // en=0 releases without a pulse and blocks new grants
        req = 32'h1 << 3;
        step();
        chk("t5_idx", {27'd0, gnt_idx}, 3);
        en = 1'b0;
        step();
        chk("t5_valid", {31'd0, gnt_valid}, 0);
        chk("t5_oh", gnt_onehot, 0);
        chk("t5_pulse", {31'd0, timeout_pulse}, 0);
        req = 32'hFFFF_FFFF;
        repeat (3) begin
            step();
            chk("t5_blocked", {31'd0, gnt_valid}, 0);
        end
        en = 1'b1;
        req = '0;
        step();

        // Reset mid-grant restores rr_ptr to 0
        mode = 1'b1;
        req = 32'h1 << 2;
        step();
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_valid", {31'd0, gnt_valid}, 0);
        chk("t6_rst_oh", gnt_onehot, 0);
        chk("t6_rst_idx", {27'd0, gnt_idx}, 0);
        reset = 1'b0;
        req = 32'h0000_0011;
        step();
        chk("t6_idx", {27'd0, gnt_idx}, 4);

        // Random traffic against the reference model
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) req = $urandom() & $urandom();
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom());
            en = ($urandom_range(0, 15) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
